// File: rtl/mxu_sequencer.sv
// Multi-tile sequencer for the systolic MXU. It reads the mode and tile count from the CSR,
// then runs load/compute/drain passes and stalls on FIFO empty/full.
module mxu_sequencer #(
  parameter int ROWS               = 3,
  parameter int COLUMNS            = 3,
  parameter int DATA_WIDTH_FIFO_IN = 64,
  parameter int DATA_WIDTH_CSR     = 8,
  parameter int ADDRESS_SIZE_CSR   = 32,
  parameter int CSR_ADDR_MODE      = 0,
  parameter int CSR_ADDR_TILES     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        glb_enable,
  input  logic                        cs_start,
  input  logic                        cs_abort,
  output logic                        cs_idle,
  output logic                        cs_ready,
  output logic                        cs_done,
  output logic                        error,
  output logic                        csr_ce,
  output logic [ADDRESS_SIZE_CSR-1:0] csr_address,
  input  logic [DATA_WIDTH_CSR-1:0]   csr_dout,
  output logic                        infifo_read,
  input  logic                        infifo_is_empty,
  output logic                        outfifo_write,
  input  logic                        outfifo_is_full,
  output logic                        enable_mxu,
  output logic                        enable_skew_ff,
  output logic                        load_weight,
  output logic                        load_activation,
  output logic                        store_activation,
  output logic [1:0]                  data_precision,
  output logic                        enable_chain,
  output logic [1:0]                  enable_fp_unit,
  output logic [DATA_WIDTH_CSR-1:0]   tiles_done,
  output logic [3:0]                  state_out
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CFG_MODE  = 4'd1,
    S_CFG_TILES = 4'd2,
    S_CFG_CHECK = 4'd3,
    S_LOAD      = 4'd4,
    S_COMPUTE   = 4'd5,
    S_DRAIN     = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  localparam int COMPUTE_CYCLES = 3 * (COLUMNS + 1) + 2 * ROWS;
  localparam int CW = $clog2(COMPUTE_CYCLES + 1);
  localparam int BEATS_MAX = (COLUMNS * 64 + DATA_WIDTH_FIFO_IN - 1) / DATA_WIDTH_FIFO_IN;
  localparam int BW = $clog2(BEATS_MAX + 1);

  // Last beat index per precision (INT8/16/32/64), rounded up to whole FIFO words.
  logic [BW-1:0] beat_last_tbl [4];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_beats
      localparam int BEATS = (COLUMNS * (8 << gi) + DATA_WIDTH_FIFO_IN - 1) / DATA_WIDTH_FIFO_IN;
      assign beat_last_tbl[gi] = BW'(BEATS - 1);
    end
  endgenerate

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [DATA_WIDTH_CSR-1:0]   count_q, count_d;
  logic [DATA_WIDTH_CSR-1:0]   tiles_done_q, tiles_done_d;
  logic [1:0]                  precision_q, precision_d;
  logic                        chain_q, chain_d;
  logic [1:0]                  fp_q, fp_d;
  logic                        error_q, error_d;
  logic                        cs_idle_q, cs_idle_d;
  logic                        cs_ready_q, cs_ready_d;
  logic                        cs_done_q, cs_done_d;
  logic                        csr_ce_q, csr_ce_d;
  logic [ADDRESS_SIZE_CSR-1:0] csr_addr_q, csr_addr_d;
  logic                        load_q, load_d;
  logic                        write_q, write_d;
  logic                        mxu_q, mxu_d;
  logic                        skew_q, skew_d;
  logic [DATA_WIDTH_CSR-1:0]   tiles_inc;
  logic [BW-1:0]               beat_last;

  assign tiles_inc = tiles_done_q + 1'b1;
  assign beat_last = beat_last_tbl[precision_q];

  // Outputs are registered: each _d below is what the block drives in the coming cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beat_d       = beat_q;
    count_d      = count_q;
    tiles_done_d = tiles_done_q;
    precision_d  = precision_q;
    chain_d      = chain_q;
    fp_d         = fp_q;
    error_d      = error_q;
    cs_idle_d    = 1'b0;
    cs_ready_d   = 1'b0;
    cs_done_d    = 1'b0;
    csr_ce_d     = 1'b0;
    csr_addr_d   = '0;
    load_d       = 1'b0;
    write_d      = 1'b0;
    mxu_d        = 1'b0;
    skew_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cs_idle_d = 1'b1;
        if (cs_start && glb_enable) begin
          state_d    = S_CFG_MODE;
          error_d    = 1'b0;
          cs_idle_d  = 1'b0;
          csr_ce_d   = 1'b1;
          csr_addr_d = ADDRESS_SIZE_CSR'(CSR_ADDR_MODE);
        end
      end
      S_CFG_MODE: begin
        state_d    = S_CFG_TILES;
        csr_ce_d   = 1'b1;
        csr_addr_d = ADDRESS_SIZE_CSR'(CSR_ADDR_TILES);
      end
      S_CFG_TILES: begin
        precision_d = csr_dout[1:0];
        chain_d     = csr_dout[2];
        fp_d        = csr_dout[4:3];
        state_d     = S_CFG_CHECK;
      end
      S_CFG_CHECK: begin
        count_d = csr_dout;
        if (csr_dout == '0 || fp_q == 2'd3) begin
          state_d   = S_ERROR;
          error_d   = 1'b1;
          cs_done_d = 1'b1;
        end else begin
          state_d      = S_LOAD;
          cs_ready_d   = 1'b1;
          tiles_done_d = '0;
          load_d       = !infifo_is_empty;
        end
      end
      S_LOAD: begin
        if (load_q) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
          mxu_d   = 1'b1;
          skew_d  = 1'b1;
        end else begin
          load_d = !infifo_is_empty;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == CW'(COMPUTE_CYCLES - 1)) begin
          state_d = S_DRAIN;
          beat_d  = '0;
          write_d = !outfifo_is_full;
          mxu_d   = !outfifo_is_full;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          mxu_d  = 1'b1;
          skew_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (write_q && beat_q == beat_last) begin
          tiles_done_d = tiles_inc;
          if (tiles_inc == count_q) begin
            state_d   = S_DONE;
            cs_done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            load_d  = !infifo_is_empty;
          end
        end else begin
          if (write_q) beat_d = beat_q + 1'b1;
          write_d = !outfifo_is_full;
          mxu_d   = !outfifo_is_full;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cs_idle_d = 1'b1;
      end
    endcase
    // Abort overrides everything; config and progress registers keep their values.
    if (cs_abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d      = S_IDLE;
      cnt_d        = cnt_q;
      beat_d       = beat_q;
      count_d      = count_q;
      tiles_done_d = tiles_done_q;
      precision_d  = precision_q;
      chain_d      = chain_q;
      fp_d         = fp_q;
      error_d      = error_q;
      cs_idle_d    = 1'b1;
      cs_ready_d   = 1'b0;
      cs_done_d    = 1'b0;
      csr_ce_d     = 1'b0;
      csr_addr_d   = '0;
      load_d       = 1'b0;
      write_d      = 1'b0;
      mxu_d        = 1'b0;
      skew_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      count_q      <= '0;
      tiles_done_q <= '0;
      precision_q  <= '0;
      chain_q      <= 1'b0;
      fp_q         <= '0;
      error_q      <= 1'b0;
      cs_idle_q    <= 1'b1;
      cs_ready_q   <= 1'b0;
      cs_done_q    <= 1'b0;
      csr_ce_q     <= 1'b0;
      csr_addr_q   <= '0;
      load_q       <= 1'b0;
      write_q      <= 1'b0;
      mxu_q        <= 1'b0;
      skew_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      count_q      <= count_d;
      tiles_done_q <= tiles_done_d;
      precision_q  <= precision_d;
      chain_q      <= chain_d;
      fp_q         <= fp_d;
      error_q      <= error_d;
      cs_idle_q    <= cs_idle_d;
      cs_ready_q   <= cs_ready_d;
      cs_done_q    <= cs_done_d;
      csr_ce_q     <= csr_ce_d;
      csr_addr_q   <= csr_addr_d;
      load_q       <= load_d;
      write_q      <= write_d;
      mxu_q        <= mxu_d;
      skew_q       <= skew_d;
    end
  end

  assign cs_idle          = cs_idle_q;
  assign cs_ready         = cs_ready_q;
  assign cs_done          = cs_done_q;
  assign error            = error_q;
  assign csr_ce           = csr_ce_q;
  assign csr_address      = csr_addr_q;
  assign infifo_read      = load_q;
  assign load_weight      = load_q;
  assign load_activation  = load_q;
  assign outfifo_write    = write_q;
  assign store_activation = write_q;
  assign enable_mxu       = mxu_q;
  assign enable_skew_ff   = skew_q;
  assign data_precision   = precision_q;
  assign enable_chain     = chain_q;
  assign enable_fp_unit   = fp_q;
  assign tiles_done       = tiles_done_q;
  assign state_out        = state_q;

endmodule

// File: tb/tb_mxu_sequencer.sv
// Directed bench for mxu_sequencer: a CSR responder, a cycle monitor and a job scoreboard
// holding expected write/read/tile/error results per started job.
module tb_mxu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        glb_enable = 1'b1;
  logic        cs_start = 1'b0;
  logic        cs_abort = 1'b0;
  logic        cs_idle, cs_ready, cs_done, error, csr_ce;
  logic [31:0] csr_address;
  logic [7:0]  csr_dout = 8'd0;
  logic        infifo_read;
  logic        infifo_is_empty = 1'b0;
  logic        outfifo_write;
  logic        outfifo_is_full = 1'b0;
  logic        enable_mxu, enable_skew_ff, load_weight, load_activation, store_activation;
  logic [1:0]  data_precision;
  logic        enable_chain;
  logic [1:0]  enable_fp_unit;
  logic [7:0]  tiles_done;
  logic [3:0]  state_out;

  mxu_sequencer dut (
    .clk(clk), .reset(reset), .glb_enable(glb_enable),
    .cs_start(cs_start), .cs_abort(cs_abort),
    .cs_idle(cs_idle), .cs_ready(cs_ready), .cs_done(cs_done), .error(error),
    .csr_ce(csr_ce), .csr_address(csr_address), .csr_dout(csr_dout),
    .infifo_read(infifo_read), .infifo_is_empty(infifo_is_empty),
    .outfifo_write(outfifo_write), .outfifo_is_full(outfifo_is_full),
    .enable_mxu(enable_mxu), .enable_skew_ff(enable_skew_ff),
    .load_weight(load_weight), .load_activation(load_activation),
    .store_activation(store_activation),
    .data_precision(data_precision), .enable_chain(enable_chain),
    .enable_fp_unit(enable_fp_unit), .tiles_done(tiles_done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // CSR bank: registered read, data valid the cycle after csr_ce.
  logic [7:0] csr_mem [2];
  always @(posedge clk) begin
    if (csr_ce) csr_dout <= (csr_address == 32'd1) ? csr_mem[1] : csr_mem[0];
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycle monitor sampled on the falling edge.
  int         wr_cnt, rd_cnt, skew_cnt, viol, cmp_run, cmp_entries, drain_run;
  int         drain_lens[$];
  logic [3:0] prev_state = 4'd0;
  logic       full_prev = 1'b0;

  always @(posedge clk) full_prev = outfifo_is_full;

  always @(negedge clk) begin
    if (outfifo_write) wr_cnt++;
    if (outfifo_write && full_prev) viol++;
    if (infifo_read) rd_cnt++;
    if (enable_skew_ff) skew_cnt++;
    if (state_out == 4'd5) begin
      if (prev_state != 4'd5) begin
        cmp_entries++;
        cmp_run = 0;
      end
      cmp_run++;
    end
    if (state_out == 4'd6) drain_run++;
    else if (drain_run != 0) begin
      drain_lens.push_back(drain_run);
      drain_run = 0;
    end
    prev_state = state_out;
  end

  typedef struct {
    int   wr;
    int   rd;
    int   tiles;
    logic err;
  } exp_t;
  exp_t sb_q[$];

  function automatic int beats_for(input int prec);
    int w;
    w = 8 << prec;
    return (3 * w + 63) / 64;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon();
    wr_cnt = 0; rd_cnt = 0; skew_cnt = 0; viol = 0;
    cmp_run = 0; cmp_entries = 0; drain_run = 0;
    drain_lens.delete();
  endtask

  // Loads the CSR, records the expected outcome, and pulses cs_start for one sampled edge.
  task automatic start_job(input logic [7:0] mode, input int tiles, input int prev_tiles);
    exp_t e;
    csr_mem[0] = mode;
    csr_mem[1] = 8'(tiles);
    clr_mon();
    e.err = (tiles == 0) || (mode[4:3] == 2'd3);
    if (e.err) begin
      e.wr = 0; e.rd = 0; e.tiles = prev_tiles;
    end else begin
      e.wr = tiles * beats_for(int'(mode[1:0])); e.rd = tiles; e.tiles = tiles;
    end
    sb_q.push_back(e);
    cs_start = 1'b1;
    tick();
    cs_start = 1'b0;
  endtask

  task automatic compare_job(input string name);
    exp_t e;
    e = sb_q.pop_front();
    chk({name, "_writes"}, wr_cnt, e.wr);
    chk({name, "_reads"}, rd_cnt, e.rd);
    chk({name, "_tiles_done"}, 32'(tiles_done), e.tiles);
    chk({name, "_error"}, 32'(error), 32'(e.err));
    $display("job %s: writes=%0d reads=%0d tiles_done=%0d error=%0b", name, wr_cnt, rd_cnt,
             tiles_done, error);
  endtask

  task automatic finish_job(input string name);
    int n;
    n = 0;
    while (cs_done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(n < 2000), 1);
    compare_job(name);
    tick();
    chk({name, "_done_pulse"}, 32'(cs_done), 0);
    chk({name, "_idle_after"}, 32'(cs_idle), 1);
  endtask

  initial begin
    int n;
    clr_mon();
    csr_mem[0] = 8'd0;
    csr_mem[1] = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    tick();
    chk("rst_state", 32'(state_out), 0);
    chk("rst_idle", 32'(cs_idle), 1);
    chk("rst_error", 32'(error), 0);
    chk("rst_tiles", 32'(tiles_done), 0);
    reset = 1'b1;
    tick();
    chk("rst_idle_after", 32'(cs_idle), 1);

    // INT32, one tile: start latency, compute length, two beats
    start_job(8'h02, 1, 0);
    chk("t1_cfg_mode", 32'(state_out), 1);
    chk("t1_csr_ce", 32'(csr_ce), 1);
    chk("t1_addr_mode", csr_address, 0);
    tick();
    chk("t1_addr_tiles", csr_address, 1);
    tick();
    chk("t1_ready_early", 32'(cs_ready), 0);
    tick();
    chk("t1_ready", 32'(cs_ready), 1);
    chk("t1_load_state", 32'(state_out), 4);
    finish_job("int32");
    chk("int32_compute_len", cmp_run, 18);
    chk("int32_skew_cycles", skew_cnt, 18);
    chk("int32_precision", 32'(data_precision), 2);

    // INT64, four tiles, output FIFO full for 5 cycles after beat 1 of tile 2
    start_job(8'h03, 4, 1);
    n = 0;
    while (wr_cnt < 4 && n < 2000) begin
      tick();
      n++;
    end
    chk("int64_beat1_seen", 32'(n < 2000), 1);
    outfifo_is_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 outfifo_is_full = 1'b0;
    finish_job("int64");
    chk("int64_write_while_full", viol, 0);
    chk("int64_drain_count", drain_lens.size(), 4);
    chk("int64_drain1_len", drain_lens[0], 3);
    chk("int64_drain2_len", drain_lens[1], 8);
    chk("int64_precision", 32'(data_precision), 3);

    // INT8, two tiles, input FIFO empty for 7 cycles at tile 2 LOAD
    start_job(8'h00, 2, 4);
    n = 0;
    while (!(rd_cnt == 1 && state_out == 4'd6) && n < 2000) begin
      tick();
      n++;
    end
    chk("empty_drain_seen", 32'(n < 2000), 1);
    infifo_is_empty = 1'b1;
    repeat (7) @(posedge clk);
    #1 infifo_is_empty = 1'b0;
    tick();
    chk("empty_no_read", 32'(infifo_read), 0);
    chk("empty_reads_held", rd_cnt, 1);
    tick();
    chk("empty_read_resumes", 32'(infifo_read), 1);
    chk("empty_load_weight", 32'(load_weight), 1);
    finish_job("stall");

    // Configuration errors: zero tiles, then fp select 3
    start_job(8'h02, 0, 2);
    n = 0;
    while (cs_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("err0_state", 32'(state_out), 8);
    finish_job("err_tiles0");
    chk("err0_sticky", 32'(error), 1);
    start_job(8'h18, 3, 2);
    finish_job("err_fp3");
    chk("errfp_value", 32'(enable_fp_unit), 3);
    start_job(8'h01, 1, 2);
    chk("err_clear_on_start", 32'(error), 0);
    finish_job("int16");

    // Abort at COMPUTE cycle 10 of tile 3
    start_job(8'h04, 5, 1);
    sb_q[sb_q.size()-1].wr = 2;
    sb_q[sb_q.size()-1].rd = 3;
    sb_q[sb_q.size()-1].tiles = 2;
    n = 0;
    while (!(cmp_entries == 3 && cmp_run == 10) && n < 2000) begin
      tick();
      n++;
    end
    chk("abort_point_seen", 32'(n < 2000), 1);
    cs_abort = 1'b1;
    tick();
    cs_abort = 1'b0;
    chk("abort_state", 32'(state_out), 0);
    chk("abort_idle", 32'(cs_idle), 1);
    chk("abort_mxu", 32'(enable_mxu), 0);
    chk("abort_chain", 32'(enable_chain), 1);
    compare_job("abort");
    repeat (5) tick();
    chk("abort_no_more_writes", wr_cnt, 2);
    chk("abort_stays_idle", 32'(state_out), 0);

    // Reset in the middle of COMPUTE
    start_job(8'h03, 2, 2);
    void'(sb_q.pop_back());
    n = 0;
    while (!(state_out == 4'd5 && cmp_run == 5) && n < 2000) begin
      tick();
      n++;
    end
    chk("rst2_compute_seen", 32'(n < 2000), 1);
    reset = 1'b0;
    tick();
    chk("rst2_state", 32'(state_out), 0);
    chk("rst2_idle", 32'(cs_idle), 1);
    chk("rst2_mxu", 32'(enable_mxu), 0);
    chk("rst2_skew", 32'(enable_skew_ff), 0);
    chk("rst2_precision", 32'(data_precision), 0);
    chk("rst2_tiles", 32'(tiles_done), 0);
    chk("rst2_ready", 32'(cs_ready), 0);
    chk("rst2_done", 32'(cs_done), 0);
    chk("rst2_write", 32'(outfifo_write), 0);
    chk("rst2_csr_ce", 32'(csr_ce), 0);
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
